marquee_scroller: RTL and testbench
===================================

MARQUEE_SCROLLER -- requirements
Module: marquee_scroller

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of 7-segment digits driven (range 2..8).
REQ-002 SHALL have parameter DIVISOR, default 9000000: clk cycles per scroll tick (range 2..2^28-1).
REQ-003 SHALL have one clock and a synchronous, active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  reset.
REQ-004 SHALL have port msg_sel  input  3  message id.
REQ-005 SHALL have port mode  input  2  mode: 00 off, 01 scroll-loop, 10 scroll-once, 11 static.
REQ-006 SHALL have port pause  input  1  freeze tick counter and display while high.
REQ-007 SHALL have port display  output  DIGITS*7  segment codes; digit k at bits [7k+6:7k], digit 0 leftmost.
REQ-008 SHALL have port busy  output  1  high while a scroll pass is in progress.
REQ-009 SHALL have port done  output  1  one-clk pulse at end of a scroll-once pass.

Function
REQ-010 SHALL hold an internal message ROM of 7-bit letter codes: id0 empty; id1 HOLA; id2 CHOOSE_HERO; id3 YOU_WIN; id4 YOU_LOST; id5 PLAY_AGAIN; id6-7 empty ("_" = blank 0x00). Codes: A=119 C=57 E=121 G=111 H=118 I=25 L=56 N=84 O=63 P=115 R=80 S=109 T=120 U=28 W=29 Y=110.
REQ-011 SHALL generate a one-clk tick when the divider count reaches DIVISOR-1, then wrap the count to 0.
REQ-012 SHALL use a pass length of LEN+DIGITS characters: the message characters followed by DIGITS blanks.
REQ-013 SHALL, on each tick in scroll modes, move digit k+1 into digit k for k = 0..DIGITS-2 and load the next pass character into digit DIGITS-1.
REQ-014 SHALL, in scroll-loop, wrap the character index to 0 after the last pass character and continue without a gap cycle.
REQ-015 SHALL, in scroll-once, pulse done for 1 clk on the tick that inserts the last pass character, then hold the display all-blank and deassert busy until a restart.
REQ-016 SHALL keep busy high in scroll modes from restart until done, or permanently in loop; busy SHALL be low in off and static modes.
REQ-017 SHALL, in static mode, show characters 0..DIGITS-1 of the message on digits 0..DIGITS-1, with positions beyond LEN blank, updated 1 clk after entry.
REQ-018 SHALL force display to 0 and busy to 0 in off mode.
REQ-019 SHALL restart on any change of msg_sel or mode, seen by comparing against registered copies: display cleared, index and divider cleared on the next edge, and the first tick occurring DIVISOR clks later.
REQ-020 SHALL, when a restart coincides with a tick, apply the restart and discard the tick.
REQ-021 SHALL, while pause is high, freeze the divider, index and display; done SHALL NOT pulse; a restart SHALL still take effect.
REQ-022 SHALL treat empty messages (LEN=0) in scroll modes as a pass of DIGITS blanks; done SHALL still pulse in scroll-once.

Reset
REQ-023 SHALL, with rst_n low at a clk edge, set display=0, busy=0, done=0, divider=0, index=0, and registered msg_sel/mode = 0/00.
REQ-024 SHALL, on reset mid-pass, abandon the pass; after release, a nonzero mode SHALL be treated as a change and restart the block.

Configuration
REQ-025 SHALL, with macro MARQUEE_BLINK_EN defined, toggle static mode between message and all-blank on every tick, starting visible after entry.
REQ-026 SHALL, without MARQUEE_BLINK_EN, hold static mode steady with no blink logic synthesised.

Verification (DIVISOR=4, DIGITS=4)
REQ-027 SHALL check: reset, mode=01, msg_sel=1 -> after ticks 1..4, digit3 = H,O,L,A in turn; after tick 4 display = {d0..d3} = H,O,L,A; after tick 8 all blank; tick 9 d3 = H.
REQ-028 SHALL check: mode=10, msg_sel=1 -> done pulses exactly once, at tick 8 (clk 32 after restart); busy falls together with it; display stays 0 thereafter.
REQ-029 SHALL check: change msg_sel 1->3 mid-pass -> display 0 next clk; first tick 4 clks later loads Y into d3.
REQ-030 SHALL check: pause high for 10 clks between ticks -> display unchanged and next tick delayed by exactly 10 clks.
REQ-031 SHALL check: mode=11, msg_sel=4 -> display d0..d3 = Y,O,U,blank; with MARQUEE_BLINK_EN, all-blank after the first tick and restored after the second.
REQ-032 SHALL check: rst_n low for 1 clk during scroll-loop -> all outputs 0 next clk, then restart from index 0.

Source files
------------

// File: rtl/marquee_scroller.sv
// rtl/marquee_scroller.sv - scrolling/static 7-segment message marquee with fixed message ROM
// Optional macro MARQUEE_BLINK_EN makes static mode blink on every scroll tick.
module marquee_scroller #(
  parameter int DIGITS  = 4,
  parameter int DIVISOR = 9000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            msg_sel,
  input  logic [1:0]            mode,
  input  logic                  pause,
  output logic [DIGITS*7-1:0]   display,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_LOOP   = 2'b01;
  localparam logic [1:0] MODE_ONCE   = 2'b10;
  localparam logic [1:0] MODE_STATIC = 2'b11;

  localparam logic [6:0] CH_A = 7'd119, CH_C = 7'd57,  CH_E = 7'd121, CH_G = 7'd111;
  localparam logic [6:0] CH_H = 7'd118, CH_I = 7'd25,  CH_L = 7'd56,  CH_N = 7'd84;
  localparam logic [6:0] CH_O = 7'd63,  CH_P = 7'd115, CH_R = 7'd80,  CH_S = 7'd109;
  localparam logic [6:0] CH_T = 7'd120, CH_U = 7'd28,  CH_W = 7'd29,  CH_Y = 7'd110;
  localparam logic [6:0] CH_B = 7'd0;

  // Character 0 of each message sits in the least significant 7 bits.
  localparam logic [76:0] MSG1 = 77'({CH_A, CH_L, CH_O, CH_H});
  localparam logic [76:0] MSG2 = 77'({CH_O, CH_R, CH_E, CH_H, CH_B, CH_E, CH_S, CH_O, CH_O, CH_H, CH_C});
  localparam logic [76:0] MSG3 = 77'({CH_N, CH_I, CH_W, CH_B, CH_U, CH_O, CH_Y});
  localparam logic [76:0] MSG4 = 77'({CH_T, CH_S, CH_O, CH_L, CH_B, CH_U, CH_O, CH_Y});
  localparam logic [76:0] MSG5 = 77'({CH_N, CH_I, CH_A, CH_G, CH_A, CH_B, CH_Y, CH_A, CH_L, CH_P});

  localparam logic [27:0] DIV_LAST = 28'(DIVISOR - 1);

  function automatic logic [4:0] msg_len(input logic [2:0] id);
    case (id)
      3'd1:    msg_len = 5'd4;
      3'd2:    msg_len = 5'd11;
      3'd3:    msg_len = 5'd7;
      3'd4:    msg_len = 5'd8;
      3'd5:    msg_len = 5'd10;
      default: msg_len = 5'd0;
    endcase
  endfunction

  function automatic logic [6:0] rom_char(input logic [2:0] id, input logic [4:0] i);
    logic [76:0] m;
    case (id)
      3'd1:    m = MSG1;
      3'd2:    m = MSG2;
      3'd3:    m = MSG3;
      3'd4:    m = MSG4;
      3'd5:    m = MSG5;
      default: m = '0;
    endcase
    rom_char = (i < msg_len(id)) ? m[7*i +: 7] : 7'd0;
  endfunction

  logic [2:0]  msg_q;
  logic [1:0]  mode_q;
  logic [27:0] div_cnt;
  logic [4:0]  idx;
  logic [4:0]  last_idx;
  logic        tick;
  logic        restart;
  logic [DIGITS*7-1:0] static_disp;
`ifdef MARQUEE_BLINK_EN
  logic        blink_off;
`endif

  assign tick     = (div_cnt == DIV_LAST);
  assign restart  = (msg_sel != msg_q) || (mode != mode_q);
  assign last_idx = msg_len(msg_q) + 5'(DIGITS - 1);

  always_comb begin
    static_disp = '0;
    for (int k = 0; k < DIGITS; k++)
      static_disp[7*k +: 7] = rom_char(msg_q, 5'(k));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      msg_q     <= '0;
      mode_q    <= MODE_OFF;
      div_cnt   <= '0;
      idx       <= '0;
      display   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef MARQUEE_BLINK_EN
      blink_off <= 1'b0;
`endif
    end else if (restart) begin
      // A restart always wins, even over a coincident tick or pause.
      msg_q     <= msg_sel;
      mode_q    <= mode;
      div_cnt   <= '0;
      idx       <= '0;
      display   <= '0;
      busy      <= (mode == MODE_LOOP) || (mode == MODE_ONCE);
      done      <= 1'b0;
`ifdef MARQUEE_BLINK_EN
      blink_off <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (mode_q == MODE_OFF) begin
        display <= '0;
        busy    <= 1'b0;
        div_cnt <= '0;
      end else if (!pause) begin
        div_cnt <= tick ? '0 : div_cnt + 28'd1;
        if (mode_q == MODE_STATIC) begin
          busy <= 1'b0;
`ifdef MARQUEE_BLINK_EN
          if (tick)
            blink_off <= ~blink_off;
          display <= (blink_off ^ tick) ? '0 : static_disp;
`else
          display <= static_disp;
`endif
        end else if (busy) begin
          if (tick) begin
            display <= {rom_char(msg_q, idx), display[DIGITS*7-1:7]};
            if (idx == last_idx) begin
              idx <= '0;
              if (mode_q == MODE_ONCE) begin
                done <= 1'b1;
                busy <= 1'b0;
              end
            end else begin
              idx <= idx + 5'd1;
            end
          end
        end else begin
          // Scroll-once pass finished: hold blank until the next restart.
          display <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_marquee_scroller.sv
// tb/tb_marquee_scroller.sv - directed self-checking bench for marquee_scroller (DIGITS=4, DIVISOR=4)
module tb_marquee_scroller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  msg_sel;
  logic [1:0]  mode;
  logic        pause;
  logic [27:0] display;
  logic        busy;
  logic        done;

  int checks = 0;
  int passed = 0;
  int failed = 0;
  int pulses;

  marquee_scroller #(.DIGITS(4), .DIVISOR(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .msg_sel (msg_sel),
    .mode    (mode),
    .pause   (pause),
    .display (display),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; msg_sel = 3'd0; mode = 2'b00; pause = 1'b0;
    step(2);
    check("reset_display", 32'(display), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);

    // Scroll-loop HOLA
    rst_n = 1'b1; mode = 2'b01; msg_sel = 3'd1;
    step(1);
    check("loop_restart_display", 32'(display), 32'd0);
    check("loop_restart_busy", 32'(busy), 32'd1);
    step(4); check("loop_tick1_d3", 32'(display[27:21]), 32'd118);
    step(4); check("loop_tick2_d3", 32'(display[27:21]), 32'd63);
    step(4); check("loop_tick3_d3", 32'(display[27:21]), 32'd56);
    step(4); check("loop_tick4_d3", 32'(display[27:21]), 32'd119);
    check("loop_tick4_full", 32'(display), 32'({7'd119, 7'd56, 7'd63, 7'd118}));
    step(16); check("loop_tick8_blank", 32'(display), 32'd0);
    check("loop_busy_held", 32'(busy), 32'd1);
    step(4); check("loop_tick9_wrap", 32'(display), 32'({7'd118, 21'd0}));

    // Pause for 10 clks between ticks delays the next tick by 10
    step(2);
    pause = 1'b1;
    step(10);
    check("pause_frozen", 32'(display), 32'({7'd118, 21'd0}));
    pause = 1'b0;
    step(1);
    check("pause_no_early_tick", 32'(display), 32'({7'd118, 21'd0}));
    step(1);
    check("pause_delayed_tick", 32'(display), 32'({7'd63, 7'd118, 14'd0}));

    // Reset mid-pass, then restart from index 0
    rst_n = 1'b0;
    step(1);
    check("midreset_display", 32'(display), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    step(1);
    check("postreset_busy", 32'(busy), 32'd1);
    step(4);
    check("postreset_first_tick", 32'(display), 32'({7'd118, 21'd0}));

    // msg_sel change mid-pass
    step(2);
    msg_sel = 3'd3;
    step(1);
    check("msgchg_cleared", 32'(display), 32'd0);
    step(3);
    check("msgchg_no_early_tick", 32'(display), 32'd0);
    step(1);
    check("msgchg_first_Y", 32'(display), 32'({7'd110, 21'd0}));

    // Scroll-once HOLA: done at clk 32 after restart
    mode = 2'b10; msg_sel = 3'd1;
    step(1);
    check("once_busy_start", 32'(busy), 32'd1);
    pulses = 0;
    for (int i = 0; i < 31; i++) begin
      step(1);
      if (done) pulses++;
    end
    check("once_no_early_done", 32'(pulses), 32'd0);
    check("once_busy_before_done", 32'(busy), 32'd1);
    step(1);
    check("once_done_pulse", 32'(done), 32'd1);
    check("once_busy_fall", 32'(busy), 32'd0);
    check("once_display_blank", 32'(display), 32'd0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (done || display != 28'd0 || busy) pulses++;
    end
    check("once_quiet_after", 32'(pulses), 32'd0);

    // Empty message in scroll-once still pulses done after DIGITS ticks
    msg_sel = 3'd0;
    step(1);
    check("empty_busy", 32'(busy), 32'd1);
    step(15);
    check("empty_no_early_done", 32'(done), 32'd0);
    step(1);
    check("empty_done", 32'(done), 32'd1);

    // Static YOU_LOST
    mode = 2'b11; msg_sel = 3'd4;
    step(1);
    check("static_entry_clear", 32'(display), 32'd0);
    check("static_busy", 32'(busy), 32'd0);
    step(1);
    check("static_show", 32'(display), 32'({7'd0, 7'd28, 7'd63, 7'd110}));
    step(3);
`ifdef MARQUEE_BLINK_EN
    check("static_blink_off", 32'(display), 32'd0);
`else
    check("static_steady1", 32'(display), 32'({7'd0, 7'd28, 7'd63, 7'd110}));
`endif
    step(4);
    check("static_tick2", 32'(display), 32'({7'd0, 7'd28, 7'd63, 7'd110}));

    // Off mode
    mode = 2'b00;
    step(1);
    check("off_display", 32'(display), 32'd0);
    check("off_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
